// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bus bundle shared by the register slice and its neighbours.
// The master modport drives requests (AW/W/AR) and accepts responses (B/R);
// the slave modport is the mirror image.
interface rggen_axi4lite_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   // write address channel
   logic                     awvalid;
   logic                     awready;
   logic [ADDRESS_WIDTH-1:0] awaddr;
   logic [2:0]               awprot;
   // write data channel
   logic                     wvalid;
   logic                     wready;
   logic [BUS_WIDTH-1:0]     wdata;
   logic [STRB_WIDTH-1:0]    wstrb;
   // write response channel
   logic                     bvalid;
   logic                     bready;
   logic [1:0]               bresp;
   // read address channel
   logic                     arvalid;
   logic                     arready;
   logic [ADDRESS_WIDTH-1:0] araddr;
   logic [2:0]               arprot;
   // read data channel
   logic                     rvalid;
   logic                     rready;
   logic [BUS_WIDTH-1:0]     rdata;
   logic [1:0]               rresp;

   modport master (
      output awvalid, awaddr, awprot,
      input  awready,
      output wvalid, wdata, wstrb,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arprot,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awprot,
      output awready,
      input  wvalid, wdata, wstrb,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arprot,
      output arready,
      output rvalid, rdata, rresp,
      input  rready
   );
endinterface

// File: rtl/rggen_axi4lite_slice.sv
// AXI4-Lite register slice: an independent two-entry skid buffer on each of
// the five channels, so that no valid, ready or payload path crosses the
// slice combinationally. Either direction can be reduced to plain wires.

// One channel: two-entry skid buffer, or a wire when ENABLE is 0.
module rggen_axi4lite_slice_channel #(
   parameter int WIDTH  = 1,
   parameter bit ENABLE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_data,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic [WIDTH-1:0] dst_data
);
   if (ENABLE) begin : g_slice
      typedef enum logic [1:0] {
         EMPTY = 2'd0,
         BUSY  = 2'd1,
         FULL  = 2'd2
      } state_e;

      state_e           state;
      state_e           state_next;
      logic             ready_q;
      logic             valid_q;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;
      logic             push;
      logic             pop;
      logic             load_main_src;
      logic             load_main_skid;
      logic             load_skid;

      // Handshakes are qualified only by registered flags, never by the other side.
      assign push = src_valid && ready_q;
      assign pop  = valid_q && dst_ready;

      // Next-state and register-load decode.
      always_comb begin
         // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
         state_next     = state;
         load_main_src  = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
         unique case (state)
            EMPTY: begin
               if (push) begin
                  state_next    = BUSY;
                  load_main_src = 1'b1;
               end
            end
            BUSY: begin
               if (push && !pop) begin
                  state_next = FULL;
                  load_skid  = 1'b1;
               end else if (pop && !push) begin
                  state_next = EMPTY;
               end else if (push && pop) begin
                  load_main_src = 1'b1;
               end
            end
            FULL: begin
               // src_ready is low here, so no push can coincide with this pop.
               if (pop) begin
                  state_next     = BUSY;
                  load_main_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end

      // State register plus registered ready/valid flags derived from the next state.
      always_ff @(posedge i_clk or posedge i_rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         if (i_rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
            valid_q <= (state_next != EMPTY);
         end
      end

      // Payload storage; meaningful only while the flags say so.
      always_ff @(posedge i_clk) begin
         // NOTE: payload registers are deliberately left out of reset; valid gates their use.
         if (load_main_src) begin
            main_q <= src_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= src_data;
         end
      end

      assign src_ready = ready_q;
      assign dst_valid = valid_q;
      assign dst_data  = main_q;
   end else begin : g_wire
      assign dst_valid = src_valid;
      assign dst_data  = src_data;
      assign src_ready = dst_ready;
   end
endmodule

// Top level: five channel buffers between the interconnect and the adapter.
module rggen_axi4lite_slice #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter bit REQUEST_SLICE  = 1'b1,
   parameter bit RESPONSE_SLICE = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   rggen_axi4lite_if.slave   slave_if,
   rggen_axi4lite_if.master  master_if
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;
   localparam int AX_WIDTH   = ADDRESS_WIDTH + 3;
   localparam int W_WIDTH    = BUS_WIDTH + STRB_WIDTH;
   localparam int B_WIDTH    = 2;
   localparam int R_WIDTH    = BUS_WIDTH + 2;

   logic [AX_WIDTH-1:0] aw_src;
   logic [AX_WIDTH-1:0] aw_dst;
   logic [W_WIDTH-1:0]  w_src;
   logic [W_WIDTH-1:0]  w_dst;
   logic [AX_WIDTH-1:0] ar_src;
   logic [AX_WIDTH-1:0] ar_dst;
   logic [B_WIDTH-1:0]  b_src;
   logic [B_WIDTH-1:0]  b_dst;
   logic [R_WIDTH-1:0]  r_src;
   logic [R_WIDTH-1:0]  r_dst;

   assign aw_src = {slave_if.awaddr, slave_if.awprot};
   assign {master_if.awaddr, master_if.awprot} = aw_dst;
   assign w_src  = {slave_if.wdata, slave_if.wstrb};
   assign {master_if.wdata, master_if.wstrb} = w_dst;
   assign ar_src = {slave_if.araddr, slave_if.arprot};
   assign {master_if.araddr, master_if.arprot} = ar_dst;
   assign b_src  = master_if.bresp;
   assign slave_if.bresp = b_dst;
   assign r_src  = {master_if.rdata, master_if.rresp};
   assign {slave_if.rdata, slave_if.rresp} = r_dst;

   rggen_axi4lite_slice_channel #(
      .WIDTH (AX_WIDTH),
      .ENABLE(REQUEST_SLICE)
   ) u_aw (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_valid(slave_if.awvalid),
      .src_ready(slave_if.awready),
      .src_data (aw_src),
      .dst_valid(master_if.awvalid),
      .dst_ready(master_if.awready),
      .dst_data (aw_dst)
   );

   rggen_axi4lite_slice_channel #(
      .WIDTH (W_WIDTH),
      .ENABLE(REQUEST_SLICE)
   ) u_w (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_valid(slave_if.wvalid),
      .src_ready(slave_if.wready),
      .src_data (w_src),
      .dst_valid(master_if.wvalid),
      .dst_ready(master_if.wready),
      .dst_data (w_dst)
   );

   rggen_axi4lite_slice_channel #(
      .WIDTH (AX_WIDTH),
      .ENABLE(REQUEST_SLICE)
   ) u_ar (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_valid(slave_if.arvalid),
      .src_ready(slave_if.arready),
      .src_data (ar_src),
      .dst_valid(master_if.arvalid),
      .dst_ready(master_if.arready),
      .dst_data (ar_dst)
   );

   rggen_axi4lite_slice_channel #(
      .WIDTH (B_WIDTH),
      .ENABLE(RESPONSE_SLICE)
   ) u_b (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_valid(master_if.bvalid),
      .src_ready(master_if.bready),
      .src_data (b_src),
      .dst_valid(slave_if.bvalid),
      .dst_ready(slave_if.bready),
      .dst_data (b_dst)
   );

   rggen_axi4lite_slice_channel #(
      .WIDTH (R_WIDTH),
      .ENABLE(RESPONSE_SLICE)
   ) u_r (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_valid(master_if.rvalid),
      .src_ready(master_if.rready),
      .src_data (r_src),
      .dst_valid(slave_if.rvalid),
      .dst_ready(slave_if.rready),
      .dst_data (r_dst)
   );
endmodule
